rad4_pp_accum_64: RTL

RAD4_PP_ACCUM_64 -- requirements
Module: rad4_pp_accum_64

---
 rtl/rad4_pp_accum_64_if.sv | 22 ++
 rtl/rad4_pp_accum_64.sv | 92 +++++++++
 2 files changed

// File: rtl/rad4_pp_accum_64_if.sv
// Partial-product beat stream in, accumulated product out, for the radix-4 Booth accumulator.
interface rad4_pp_accum_64_if;
  logic signed [63:0] i_PP;
  logic               i_PP_VALID;
  logic               i_PP_LAST;
  logic               o_PP_READY;
  logic signed [63:0] o_P;
  logic               o_P_VALID;
  logic               i_P_READY;
  logic               o_ERR;
  logic               o_BUSY;

  modport master (
    output i_PP, i_PP_VALID, i_PP_LAST, i_P_READY,
    input  o_PP_READY, o_P, o_P_VALID, o_ERR, o_BUSY
  );

  modport slave (
    input  i_PP, i_PP_VALID, i_PP_LAST, i_P_READY,
    output o_PP_READY, o_P, o_P_VALID, o_ERR, o_BUSY
  );
endinterface

// File: rtl/rad4_pp_accum_64.sv
// Radix-4 Booth partial-product accumulator: beat k is weighted by 4^k and summed modulo 2^64.
module rad4_pp_accum_64 (
  input logic               i_CLK,
  input logic               i_RST,
  rad4_pp_accum_64_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  logic [3:0]         k;
  logic signed [63:0] acc;
  logic               err;
  logic               pp_ready;
  logic               p_valid;
  logic               busy;
  logic               accept;

  // Bits pushed past bit 63 are dropped: the sum is defined modulo 2^64.
  function automatic logic signed [63:0] weight_pp(input logic signed [63:0] pp,
                                                   input logic [3:0] idx);
    return pp << {idx, 1'b0};
  endfunction

  always_comb accept = bus.i_PP_VALID && pp_ready;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= IDLE;
      k        <= '0;
      acc      <= '0;
      err      <= 1'b0;
      pp_ready <= 1'b1;
      p_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= bus.i_PP;
            k    <= 4'd1;
            err  <= 1'b0;
            busy <= 1'b1;
            if (bus.i_PP_LAST) begin
              state    <= DONE;
              pp_ready <= 1'b0;
              p_valid  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + weight_pp(bus.i_PP, k);
            k   <= k + 4'd1;
            // The 16th beat closes the operation; without LAST it is flagged.
            if (bus.i_PP_LAST || k == 4'd15) begin
              state    <= DONE;
              pp_ready <= 1'b0;
              p_valid  <= 1'b1;
              err      <= (k == 4'd15) && !bus.i_PP_LAST;
            end
          end
        end
        DONE: begin
          if (bus.i_P_READY) begin
            state    <= IDLE;
            k        <= '0;
            pp_ready <= 1'b1;
            p_valid  <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          k        <= '0;
          pp_ready <= 1'b1;
          p_valid  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_PP_READY = pp_ready;
  assign bus.o_P        = acc;
  assign bus.o_P_VALID  = p_valid;
  assign bus.o_ERR      = err;
  assign bus.o_BUSY     = busy;

endmodule
